// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file widths and operand-fetch state encoding
// Contents:
//   DATA_W        register / operand width
//   REG_AW        register index width (8 registers)
//   fetch_state_t IDLE / RD_A / RD_B / DONE, reused by the controller FSM
package regfile_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        RD_B = 2'd2,
        DONE = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/operand_latch.sv
// rtl/operand_latch.sv - load-enabled operand register with asynchronous active-low clear
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low clear
//   load     capture d at the next edge
//   d        data to capture
//   q        held value
module operand_latch #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - sequences two operand reads through a single regfile read port
// Optional feature macro: OPERAND_FETCH_BYPASS_EN (write-through forwarding of snooped writes)
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    fetch request, sampled only in IDLE
//   ack      consumer accepts operands, sampled only in DONE
//   rn, rm   operand A / B register indices, captured on accepted start
//   readnum  regfile read select
//   rf_data  regfile combinational read data
//   wr_en, wr_num, wr_data  snooped regfile write port
//   a_out, b_out  latched operands
//   valid    operands ready, held until ack
//   busy     high in any state other than IDLE
module operand_fetch #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int REG_AW = regfile_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              ack,
    input  logic [REG_AW-1:0] rn,
    input  logic [REG_AW-1:0] rm,
    output logic [REG_AW-1:0] readnum,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_num,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              valid,
    output logic              busy
);

    import regfile_pkg::*;

    fetch_state_t      state;
    logic [REG_AW-1:0] rn_q;
    logic [REG_AW-1:0] rm_q;
    logic [DATA_W-1:0] fetch_data;
    logic              same_reg;
    logic              load_a;
    logic              load_b;

    assign same_reg = (rn_q == rm_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            rn_q  <= '0;
            rm_q  <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rn_q  <= rn;
                        rm_q  <= rm;
                        busy  <= 1'b1;
                        state <= RD_A;
                    end
                end
                RD_A: begin
                    // One read serves both operands when they name the same register.
                    if (same_reg) begin
                        valid <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= RD_B;
                    end
                end
                RD_B: begin
                    valid <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    // ack wins over a simultaneous start; that start is dropped.
                    if (ack) begin
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        readnum = '0;
        case (state)
            RD_A:    readnum = rn_q;
            RD_B:    readnum = rm_q;
            default: readnum = '0;
        endcase
    end

`ifdef OPERAND_FETCH_BYPASS_EN
    // Forward a same-cycle write to the register being read instead of the stale array value.
    assign fetch_data = (wr_en && (wr_num == readnum)) ? wr_data : rf_data;
`else
    // Old-value read-during-write: the snooped write port is not consulted.
    logic unused_snoop;
    assign unused_snoop = ^{wr_en, wr_num, wr_data};
    assign fetch_data   = rf_data;
`endif

    assign load_a = (state == RD_A);
    assign load_b = ((state == RD_A) && same_reg) || (state == RD_B);

    operand_latch #(.W(DATA_W)) u_latch_a (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load_a),
        .d       (fetch_data),
        .q       (a_out)
    );

    operand_latch #(.W(DATA_W)) u_latch_b (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load_b),
        .d       (fetch_data),
        .q       (b_out)
    );

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - scoreboard bench for operand_fetch with a behavioural regfile
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        ack = 1'b0;
    logic [2:0]  rn = 3'd0;
    logic [2:0]  rm = 3'd0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_num = 3'd0;
    logic [15:0] wr_data = 16'd0;
    logic [2:0]  readnum;
    logic [15:0] rf_data;
    logic [15:0] a_out;
    logic [15:0] b_out;
    logic        valid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb_q[$];
    logic [31:0] sb_e;
    logic [15:0] model[8];
    logic [15:0] rf[8];
    logic        prev_valid = 1'b0;

    always #5 clk = ~clk;

    // Regfile: synchronous write, combinational read (old value during a same-cycle write).
    always @(posedge clk) if (wr_en) rf[wr_num] <= wr_data;
    assign rf_data = rf[readnum];

    operand_fetch dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .ack     (ack),
        .rn      (rn),
        .rm      (rm),
        .readnum (readnum),
        .rf_data (rf_data),
        .wr_en   (wr_en),
        .wr_num  (wr_num),
        .wr_data (wr_data),
        .a_out   (a_out),
        .b_out   (b_out),
        .valid   (valid),
        .busy    (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every rising valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid actual=%0h expected=none", {a_out, b_out});
            end else begin
                sb_e = sb_q.pop_front();
                chk("result", {a_out, b_out}, sb_e);
            end
        end
        prev_valid = valid;
    end

    task automatic wait_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic rf_write(input logic [2:0] n, input logic [15:0] d);
        wr_en = 1'b1; wr_num = n; wr_data = d;
        wait_pos();
        wr_en = 1'b0;
        model[n] = d;
    endtask

    task automatic fetch(input logic [2:0] n, input logic [2:0] m, input int hold,
                         input bit glitch, input bit collide, input bit bwr,
                         input logic [15:0] wval);
        logic [15:0] ea;
        logic [15:0] eb;
        int cnt;
        ea = model[n];
`ifdef OPERAND_FETCH_BYPASS_EN
        if (bwr) ea = wval;
`endif
        eb = (n == m) ? ea : model[m];
        sb_q.push_back({ea, eb});

        start = 1'b1; rn = n; rm = m;
        wait_pos();
        start = 1'b0;
        rn = 3'($urandom_range(7));
        rm = 3'($urandom_range(7));
        chk("rda_readnum", readnum, n);
        chk("rda_busy", busy, 1);
        chk("rda_valid", valid, 0);
        if (bwr) begin
            wr_en = 1'b1; wr_num = n; wr_data = wval;
        end
        if (glitch) start = 1'b1;
        wait_pos();
        wr_en = 1'b0;
        start = 1'b0;
        if (bwr) model[n] = wval;
        if (n != m) begin
            chk("rdb_readnum", readnum, m);
            chk("rdb_busy", busy, 1);
            chk("rdb_valid", valid, 0);
            wait_pos();
        end
        cnt = 0;
        while (!valid && cnt < 8) begin
            wait_pos();
            cnt++;
        end
        chk("latency_extra", cnt, 0);
        chk("done_readnum", readnum, 0);
        chk("done_busy", busy, 1);
        for (int i = 0; i < hold; i++) begin
            wait_pos();
            chk("hold", {valid, a_out, b_out}, {1'b1, ea, eb});
        end
        ack = 1'b1;
        if (collide) start = 1'b1;
        wait_pos();
        ack = 1'b0;
        start = 1'b0;
        chk("ack_valid", valid, 0);
        chk("ack_busy", busy, 0);
        chk("idle_readnum", readnum, 0);
        chk("idle_hold", {a_out, b_out}, {ea, eb});
        if (collide) begin
            wait_pos();
            chk("collide_dropped", busy, 0);
        end
    endtask

    initial begin
        // Preload while in reset; R1=2, R3=7, others random.
        for (int r = 0; r < 8; r++) begin
            rf_write(3'(r), (r == 1) ? 16'h0002 : (r == 3) ? 16'h0007 : 16'($urandom));
        end
        chk("rst_state", {valid, busy, readnum, a_out, b_out}, 0);
        reset_n = 1'b1;
        wait_pos();

        fetch(3'd1, 3'd3, 10, 0, 0, 0, 16'h0);
        fetch(3'd1, 3'd1, 2, 0, 0, 0, 16'h0);
        fetch(3'd1, 3'd3, 1, 1, 1, 0, 16'h0);

        // Async reset in the middle of RD_B.
        start = 1'b1; rn = 3'd1; rm = 3'd3;
        wait_pos();
        start = 1'b0;
        wait_pos();
        chk("pre_rst_readnum", readnum, 3);
        #2 reset_n = 1'b0;
        #1 chk("async_rst", {valid, busy, readnum, a_out, b_out}, 0);
        wait_pos();
        reset_n = 1'b1;
        wait_pos();
        chk("post_rst_idle", {valid, busy}, 0);
        fetch(3'd3, 3'd1, 0, 0, 0, 0, 16'h0);

        // Write to R1 during its RD_A cycle.
        fetch(3'd1, 3'd3, 0, 0, 0, 1, 16'h0003);
        chk("rf_after_bypass", rf[1], 16'h0003);

        for (int it = 0; it < 24; it++) begin
            logic [2:0] n;
            logic [2:0] m;
            if ($urandom_range(1) == 1) rf_write(3'($urandom_range(7)), 16'($urandom));
            n = 3'($urandom_range(7));
            m = ($urandom_range(2) == 0) ? n : 3'($urandom_range(7));
            fetch(n, m, $urandom_range(3), 1'($urandom_range(1)), 1'($urandom_range(1)),
                  ($urandom_range(3) == 0), 16'($urandom));
        end

        repeat (3) wait_pos();
        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
